// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller.
// Holds the FSM state encoding and the buffered-entry record passed to decode.
package fetch_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
    typedef logic        u1;

    localparam u64 PC_RESET_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        u64 pc;
        u32 instr;
        u1  misalign;
    } fetch_out_t;

endpackage

// File: rtl/fetch_perf.sv
// Fetch performance counters: accepted instructions, decode-stall cycles, dropped responses.
// Latency: counts land one cycle after the event; never backpressures, all counters wrap.
// Backpressure: none, pure observer of the fetch handshake.
module fetch_perf
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        out_valid,
    input  logic        out_ready,
    input  logic        drop,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_stall_cycles,
    output logic [31:0] perf_discarded
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
            perf_discarded    <= '0;
        end else begin
            if (out_valid && out_ready)
                perf_fetched <= perf_fetched + 64'd1;
            if (out_valid && !out_ready)
                perf_stall_cycles <= perf_stall_cycles + 64'd1;
            if (drop)
                perf_discarded <= perf_discarded + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC owner: one ibus request in flight, one-entry output buffer to decode, redirect drain.
// Latency: iresp_ok to out_valid 1 cycle; redirect to new request 1 cycle (or after stale response).
// Backpressure: out_ready low holds the buffer and blocks new requests. FETCH_PERF_EN adds counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT,
    parameter int XLEN     = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_ok,
    input  logic [31:0]     iresp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_misalign,
    input  logic            out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_stall_cycles,
    output logic [31:0]     perf_discarded
`endif
);

    fetch_state_t state, state_n;
    u64           pc, pc_n;
    u64           old_addr, old_addr_n;
    fetch_out_t   out_buf, out_buf_n;
    logic         out_valid_n;
    logic         aligned;

    assign aligned = (pc[1:0] == 2'b00);

    // Request is a pure function of state/pc/old_addr so no iresp_ok -> ireq path exists.
    assign ireq_valid = !reset && ((state == FETCH && aligned) || state == DISCARD);
    assign ireq_addr  = (state == DISCARD) ? old_addr : pc;

    assign out_pc       = out_buf.pc;
    assign out_instr    = out_buf.instr;
    assign out_misalign = out_buf.misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= PC_RESET;
            old_addr  <= '0;
            out_buf   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            old_addr  <= old_addr_n;
            out_buf   <= out_buf_n;
            out_valid <= out_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        old_addr_n  = old_addr;
        out_buf_n   = out_buf;
        out_valid_n = out_valid;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    // Request still outstanding: remember it so the stale reply can be drained.
                    if (aligned && !iresp_ok) begin
                        old_addr_n = pc;
                        state_n    = DISCARD;
                    end
                end else if (!aligned) begin
                    out_valid_n = 1'b1;
                    out_buf_n   = '{pc: pc, instr: '0, misalign: 1'b1};
                    state_n     = HOLD;
                end else if (iresp_ok) begin
                    out_valid_n = 1'b1;
                    out_buf_n   = '{pc: pc, instr: iresp_data, misalign: 1'b0};
                    pc_n        = pc + 64'd4;
                    state_n     = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    out_valid_n = 1'b0;
                    pc_n        = redirect_pc;
                    state_n     = FETCH;
                end else if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = FETCH;
                end
            end
            DISCARD: begin
                if (redirect_valid)
                    pc_n = redirect_pc;
                if (iresp_ok)
                    state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic drop;

    assign drop = iresp_ok && ((state == FETCH && redirect_valid && aligned) || state == DISCARD);

    fetch_perf u_perf (
        .clk               (clk),
        .reset             (reset),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .drop              (drop),
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_discarded    (perf_discarded)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected decode entries queued at stimulus time, popped on handshake.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        iresp_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        out_ready = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall_cycles;
    logic [31:0] perf_discarded;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    fetch_out_t exp_q[$];

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_ok       (iresp_ok),
        .iresp_data     (iresp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misalign   (out_misalign),
        .out_ready      (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_discarded    (perf_discarded)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Decode-side monitor: every accepted entry must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        fetch_out_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instr", 64'(out_instr), 64'(e.instr));
                check("out_misalign", 64'(out_misalign), 64'(e.misalign));
            end
        end
    end

    task automatic wait_req(output logic [63:0] a);
        a = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ireq_valid) begin
                a = ireq_addr;
                return;
            end
        end
        check("req_timeout", 64'(ireq_valid), 64'd1);
    endtask

    task automatic respond(input int lat, input logic [31:0] d);
        repeat (lat) @(posedge clk);
        #1 iresp_ok = 1'b1;
        iresp_data = d;
        @(posedge clk);
        #1 iresp_ok = 1'b0;
        iresp_data = '0;
    endtask

    task automatic fetch_one(input logic [63:0] exp_a, input logic [31:0] d, input logic push);
        logic [63:0] a;
        wait_req(a);
        check("ireq_addr", a, exp_a);
        if (push)
            exp_q.push_back('{pc: exp_a, instr: d, misalign: 1'b0});
        respond(2, d);
    endtask

    // Let the pending handshake complete, then stall decode.
    task automatic stall_after_accept();
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_misalign", 64'(out_misalign), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        // Sequential fetch, zero stall.
        fetch_one(64'h8000_0000, 32'h0000_0013, 1'b1);
        fetch_one(64'h8000_0004, 32'h1234_5678, 1'b1);
        fetch_one(64'h8000_0008, 32'hCAFE_F00D, 1'b1);

        // Decode stall: buffer frozen, no request, pc held.
        stall_after_accept();
        fetch_one(64'h8000_000C, 32'hA5A5_5A5A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_pc", out_pc, 64'h8000_000C);
            check("stall_out_instr", 64'(out_instr), 64'hA5A5_5A5A);
            check("stall_ireq_valid", 64'(ireq_valid), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        fetch_one(64'h8000_0010, 32'h0BAD_BEEF, 1'b1);

        // Redirect while a request is pending: stale address held until the reply drains.
        wait_req(a);
        check("pend_ireq_addr", a, 64'h8000_0014);
        @(posedge clk);
        #1 redirect(64'h8000_1000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("discard_ireq_valid", 64'(ireq_valid), 64'd1);
            check("discard_ireq_addr", ireq_addr, 64'h8000_0014);
        end
        @(posedge clk);
        #1 iresp_ok = 1'b1;
        iresp_data = 32'hDEAD_0001;
        @(posedge clk);
        #1 iresp_ok = 1'b0;
        @(negedge clk);
        check("drained_out_valid", 64'(out_valid), 64'd0);
        fetch_one(64'h8000_1000, 32'h1111_2222, 1'b1);

        // Redirect coinciding with iresp_ok: response dropped, new target fetched next cycle.
        wait_req(a);
        check("same_ireq_addr", a, 64'h8000_1004);
        @(posedge clk);
        #1 iresp_ok = 1'b1;
        iresp_data = 32'hDEAD_0002;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_3000;
        @(posedge clk);
        #1 iresp_ok = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("same_next_valid", 64'(ireq_valid), 64'd1);
        check("same_next_addr", ireq_addr, 64'h8000_3000);
        check("same_out_valid", 64'(out_valid), 64'd0);
        fetch_one(64'h8000_3000, 32'h3333_4444, 1'b1);

        // Redirect from HOLD to a misaligned target: buffer flushed, fault entry emitted.
        stall_after_accept();
        fetch_one(64'h8000_3004, 32'h5555_6666, 1'b0);
        exp_q.push_back('{pc: 64'h8000_1002, instr: 32'h0, misalign: 1'b1});
        redirect(64'h8000_1002);
        out_ready = 1'b1;
        @(negedge clk);
        check("mis_ireq_valid", 64'(ireq_valid), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 64'h8000_4000;
        @(negedge clk);
        check("fault_ireq_valid", 64'(ireq_valid), 64'd0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        fetch_one(64'h8000_4000, 32'h7777_8888, 1'b1);

        // Asynchronous reset mid-run clears the buffer immediately.
        stall_after_accept();
        fetch_one(64'h8000_4004, 32'h9999_AAAA, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_ireq_valid", 64'(ireq_valid), 64'd0);
`ifdef FETCH_PERF_EN
        check("arst_perf_fetched", perf_fetched, 64'd0);
        check("arst_perf_stall", perf_stall_cycles, 64'd0);
        check("arst_perf_discard", 64'(perf_discarded), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        // Post-reset run: 4 accepted, 3 stall cycles, 1 discarded response.
        fetch_one(64'h8000_0000, 32'h0101_0101, 1'b1);
        stall_after_accept();
        fetch_one(64'h8000_0004, 32'h0202_0202, 1'b1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        fetch_one(64'h8000_0008, 32'h0303_0303, 1'b1);
        wait_req(a);
        check("perf_pend_addr", a, 64'h8000_000C);
        @(posedge clk);
        #1 redirect(64'h8000_5000);
        @(posedge clk);
        #1 iresp_ok = 1'b1;
        @(posedge clk);
        #1 iresp_ok = 1'b0;
        fetch_one(64'h8000_5000, 32'h0404_0404, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wrap_next_addr", ireq_addr, 64'h8000_5004);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 64'd4);
        check("perf_stall_cycles", perf_stall_cycles, 64'd3);
        check("perf_discarded", 64'(perf_discarded), 64'd1);
`endif

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
